pipe_reg_hs: RTL and testbench

- Parametrised elastic pipeline: DEPTH register stages of WIDTH bits, each with a valid bit and valid/ready handshake on both ends.
- Successor to the plain free-running pipe register. Adds stalling, bubble collapse, synchronous flush and occupancy reporting.
- Sits between streaming producers and consumers (e.g. address generators, DMA/accelerator datapaths) where retiming is needed and the consumer may back-pressure.

---
 rtl/pipe_hs_stage.sv | 34 +++
 rtl/pipe_reg_hs.sv | 72 +++++++
 tb/tb_pipe_reg_hs.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hs_stage.sv
// Single elastic pipeline stage: valid bit plus payload register.
// Loads from upstream whenever the ready chain says this slot may advance.
module pipe_hs_stage #(
  parameter int WIDTH      = 8,
  parameter int RESET_DATA = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) valid_o <= 1'b0;
    else if (ready_i)     valid_o <= up_valid_i;
  end

  // Payload only moves on a real item, so bubbles leave the old data in place.
  if (RESET_DATA != 0) begin : g_rst_data
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i)          data_o <= '0;
      else if (ready_i && up_valid_i) data_o <= up_data_i;
    end
  end else begin : g_hold_data
    always_ff @(posedge clk_i) begin
      if (ready_i && up_valid_i) data_o <= up_data_i;
    end
  end

endmodule

// File: rtl/pipe_reg_hs.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both ends,
// bubble collapse, synchronous flush and occupancy count.
module pipe_reg_hs #(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 2,
  parameter  int RESET_DATA = 1,
  localparam int CNT_W      = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] count_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok   = ^{clk_i, rst_i};
    assign out_valid_o = in_valid_i & ~flush_i;
    assign out_data_o  = in_data_i;
    assign in_ready_o  = out_ready_i | flush_i;
    assign count_o     = '0;
  end else begin : g_pipe
    // vld/dat[0] is the upstream port; vld/dat[k+1] is the output of stage k.
    logic [DEPTH:0]            vld;
    logic [DEPTH:0][WIDTH-1:0] dat;
    logic [DEPTH-1:0]          rdy;
    logic [CNT_W-1:0]          cnt;

    assign vld[0] = in_valid_i;
    assign dat[0] = in_data_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      // A stage may advance if any slot from here to the output is empty,
      // or the consumer is taking the head item.
      assign rdy[k] = out_ready_i | ~(&vld[DEPTH:k+1]);

      pipe_hs_stage #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_stage (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .up_valid_i (vld[k]),
        .up_data_i  (dat[k]),
        .ready_i    (rdy[k]),
        .valid_o    (vld[k+1]),
        .data_o     (dat[k+1])
      );
    end

    always_comb begin
      cnt = '0;
      for (int k = 1; k <= DEPTH; k++) cnt = cnt + CNT_W'(vld[k]);
    end

    assign in_ready_o  = rdy[0] | flush_i;
    assign out_valid_o = vld[DEPTH];
    assign out_data_o  = dat[DEPTH];
    assign count_o     = cnt;
  end

`ifndef SYNTHESIS
  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i && DEPTH > 0) |=> $stable(out_data_o));
  a_cnt_range: assert property (@(posedge clk_i) int'(count_o) <= DEPTH);
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: directed checks on a DEPTH=3 instance plus random
// valid/ready/flush traffic on DEPTH 3/0/1/4 against a FIFO reference model.
module tb_pipe_reg_hs;

  localparam int N = 4;

  function automatic int dep(input int g);
    case (g)
      0:       return 3;
      1:       return 0;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] in_valid, out_ready, flush;
  wire  [N-1:0] in_ready, out_valid;
  logic [7:0]   in_data [N];
  wire  [7:0]   out_data [N];
  wire  [2:0]   cnt [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D  = dep(g);
    localparam int CW = (D > 0) ? $clog2(D + 1) : 1;
    wire [CW-1:0] c;
    pipe_reg_hs #(.WIDTH(8), .DEPTH(D), .RESET_DATA(1)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush[g]),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .in_data_i   (in_data[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .out_data_o  (out_data[g]),
      .count_o     (c)
    );
    assign cnt[g] = 3'(c);
  end

  // Reference model: each pipeline behaves as an in-order FIFO of capacity DEPTH.
  logic [7:0] sbq [N][$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, g, act, exp, $time);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        int d;
        logic [7:0] e;
        d = dep(g);
        if (rst) begin
          sbq[g].delete();
        end else if (d == 0) begin
          chk("bypass_valid", g, 32'(out_valid[g]), 32'(in_valid[g] & ~flush[g]));
          chk("bypass_ready", g, 32'(in_ready[g]), 32'(out_ready[g] | flush[g]));
          chk("bypass_cnt", g, 32'(cnt[g]), 0);
          if (out_valid[g]) chk("bypass_data", g, 32'(out_data[g]), 32'(in_data[g]));
        end else begin
          chk("occupancy", g, 32'(cnt[g]), sbq[g].size());
          chk("in_ready", g, 32'(in_ready[g]),
              32'(flush[g] | out_ready[g] | (sbq[g].size() < d)));
          if (out_valid[g] && out_ready[g]) begin
            if (sbq[g].size() == 0) chk("spurious_out", g, 32'(out_valid[g]), 0);
            else begin
              e = sbq[g].pop_front();
              chk("out_data", g, 32'(out_data[g]), 32'(e));
            end
          end
          if (flush[g]) sbq[g].delete();
          else if (in_valid[g] && in_ready[g]) sbq[g].push_back(in_data[g]);
        end
      end
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = '0;
    out_ready = '0;
    flush     = '0;
    for (int g = 0; g < N; g++) in_data[g] = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 0, 32'(out_valid[0]), 0);
    chk("rst_cnt",   0, 32'(cnt[0]), 0);
    chk("rst_ready", 0, 32'(in_ready[0]), 1);
    chk("rst_data",  0, 32'(out_data[0]), 0);
    chk("rst_cnt",   3, 32'(cnt[3]), 0);
    next_cyc();

    // Streaming, latency DEPTH, no gaps
    out_ready[0] = 1'b1;
    for (int c = 0; c < 21; c++) begin
      in_valid[0] = (c < 16);
      in_data[0]  = 8'(c + 1);
      @(negedge clk);
      chk("stream_valid", 0, 32'(out_valid[0]), 32'(c >= 3 && c < 19));
      if (c >= 3 && c < 19) chk("stream_data", 0, 32'(out_data[0]), 32'(c - 2));
      next_cyc();
    end

    // Full back-pressure
    out_ready[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(8'h21 + c);
      @(negedge clk);
      chk("bp_in_ready", 0, 32'(in_ready[0]), 32'(c < 3));
      next_cyc();
    end
    in_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_cnt",   0, 32'(cnt[0]), 3);
      chk("bp_valid", 0, 32'(out_valid[0]), 1);
      chk("bp_hold",  0, 32'(out_data[0]), 32'h21);
      next_cyc();
    end
    out_ready[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) chk("release_ready", 0, 32'(in_ready[0]), 1);
      chk("drain_valid", 0, 32'(out_valid[0]), 32'(c < 3));
      if (c < 3) chk("drain_data", 0, 32'(out_data[0]), 32'(8'h21 + c));
      next_cyc();
    end

    // Bubble collapse
    out_ready[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid[0] = (c == 0 || c == 3);
      in_data[0]  = (c == 0) ? 8'h41 : 8'h42;
      @(negedge clk);
      if (c == 3) chk("bubble_ready", 0, 32'(in_ready[0]), 1);
      if (c == 5) begin
        chk("bubble_cnt",  0, 32'(cnt[0]), 2);
        chk("bubble_head", 0, 32'(out_data[0]), 32'h41);
      end
      next_cyc();
    end
    out_ready[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bubble_valid", 0, 32'(out_valid[0]), 32'(c < 2));
      if (c < 2) chk("bubble_data", 0, 32'(out_data[0]), (c == 0) ? 32'h41 : 32'h42);
      next_cyc();
    end

    // Flush with a full pipe and a simultaneous input
    out_ready[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(8'h51 + c);
      next_cyc();
    end
    flush[0] = 1'b1;
    in_data[0] = 8'h5F;
    @(negedge clk);
    chk("flush_pre_cnt", 0, 32'(cnt[0]), 3);
    chk("flush_ready",   0, 32'(in_ready[0]), 1);
    next_cyc();
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("flush_cnt",   0, 32'(cnt[0]), 0);
    chk("flush_valid", 0, 32'(out_valid[0]), 0);
    chk("flush_data",  0, 32'(out_data[0]), 0);
    next_cyc();
    out_ready[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("flush_no_out", 0, 32'(out_valid[0]), 0);
      next_cyc();
    end

    // Reset and flush together
    out_ready[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(8'h61 + c);
      next_cyc();
    end
    rst = 1'b1;
    flush[0] = 1'b1;
    in_data[0] = 8'h6F;
    next_cyc();
    rst = 1'b0;
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("rstfl_cnt",   0, 32'(cnt[0]), 0);
    chk("rstfl_valid", 0, 32'(out_valid[0]), 0);
    chk("rstfl_ready", 0, 32'(in_ready[0]), 1);
    chk("rstfl_data",  0, 32'(out_data[0]), 0);
    next_cyc();

    // Random traffic on all depths, one mid-stream reset
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < N; g++) begin
        in_valid[g]  = ($urandom_range(0, 99) < 60);
        in_data[g]   = 8'($urandom);
        out_ready[g] = ($urandom_range(0, 99) < 55);
        flush[g]     = ($urandom_range(0, 99) < 2);
      end
      rst = (c == 1500);
      next_cyc();
    end
    rst = 1'b0;
    in_valid  = '0;
    flush     = '0;
    out_ready = '1;
    repeat (8) next_cyc();
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("final_cnt",   g, 32'(cnt[g]), 0);
      chk("final_model", g, sbq[g].size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
